// File: rtl/adc_poller.sv
// rtl/adc_poller.sv - Avalon-MM ADC poller: two init writes, round-robin channel reads, sweep averaging, transfer timeout
module adc_poller #(
  parameter int          N_CH     = 6,
  parameter int          DATA_W   = 12,
  parameter int          AVG_LOG2 = 0,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] INIT_WD  = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  output logic                     avm_write,
  output logic                     avm_read,
  output logic [2:0]               avm_address,
  output logic [31:0]              avm_writedata,
  input  logic [31:0]              avm_readdata,
  input  logic                     avm_waitrequest,
  output logic [N_CH*DATA_W-1:0]   ch_data,
  output logic                     sweep_done,
  output logic                     timeout_err
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SW_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int WT_W  = $clog2(TIMEOUT + 1);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [SW_W-1:0] SW_LAST = SW_W'((1 << AVG_LOG2) - 1);
  localparam logic [WT_W-1:0] WT_MAX  = WT_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR0     = 3'd1;
  localparam logic [2:0] S_WR1     = 3'd2;
  localparam logic [2:0] S_RD      = 3'd3;
  localparam logic [2:0] S_PUBLISH = 3'd4;

  logic [2:0]              r_state;
  logic [CH_W-1:0]         r_ch_idx;
  logic [SW_W-1:0]         r_sweep_cnt;
  logic [WT_W-1:0]         r_wait_cnt;
  logic                    r_init_done;
  logic [ACC_W-1:0]        r_acc [N_CH];
  logic [N_CH*DATA_W-1:0]  r_ch_data;
  logic                    r_sweep_done;
  logic                    r_timeout_err;

  logic                    w_xfer_state;
  logic                    w_timeout;
  logic                    w_req;
  logic                    w_done;
  logic                    w_first_sweep;
  logic [DATA_W-1:0]       w_sample;
  logic                    w_unused_rd;

  // The request is withdrawn combinationally in the cycle the wait counter hits its limit
  assign w_xfer_state  = (r_state == S_WR0) || (r_state == S_WR1) || (r_state == S_RD);
  assign w_timeout     = w_xfer_state && (r_wait_cnt == WT_MAX);
  assign w_req         = w_xfer_state && !w_timeout;
  assign w_done        = w_req && !avm_waitrequest;
  assign w_first_sweep = (r_sweep_cnt == '0);
  assign w_sample      = avm_readdata[DATA_W-1:0];
  assign w_unused_rd   = ^avm_readdata;

  assign avm_write     = w_req && (r_state != S_RD);
  assign avm_read      = w_req && (r_state == S_RD);
  assign avm_writedata = INIT_WD;
  assign ch_data       = r_ch_data;
  assign sweep_done    = r_sweep_done;
  assign timeout_err   = r_timeout_err;

  // Address decode: register index for init writes, channel index for reads
  always_comb begin
    avm_address = 3'd0;
    if (r_state == S_WR1) begin
      avm_address = 3'd1;
    end else if (r_state == S_RD) begin
      avm_address = 3'(r_ch_idx);
    end
  end

  // Consecutive stall cycles of the current transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (!w_xfer_state || w_done || w_timeout) begin
      r_wait_cnt <= '0;
    end else if (avm_waitrequest) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Sequencer: init writes, channel sweeps, averaging, publish and timeout recovery
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ch_idx      <= '0;
      r_sweep_cnt   <= '0;
      r_init_done   <= 1'b0;
      r_ch_data     <= '0;
      r_sweep_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_acc[k] <= '0;
      end
    end else begin
      r_sweep_done <= (r_state == S_PUBLISH);
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
        r_init_done   <= 1'b0;
        r_ch_idx      <= '0;
        r_sweep_cnt   <= '0;
        r_state       <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable) begin
              r_state <= r_init_done ? S_RD : S_WR0;
            end
          end
          S_WR0: begin
            if (w_done) begin
              r_state <= S_WR1;
            end
          end
          S_WR1: begin
            if (w_done) begin
              r_init_done <= 1'b1;
              r_state     <= S_RD;
            end
          end
          S_RD: begin
            if (w_done) begin
              for (int k = 0; k < N_CH; k++) begin
                if (CH_W'(k) == r_ch_idx) begin
                  r_acc[k] <= w_first_sweep ? ACC_W'(w_sample)
                                            : r_acc[k] + ACC_W'(w_sample);
                end
              end
              if (r_ch_idx == CH_LAST) begin
                r_ch_idx <= '0;
                if (r_sweep_cnt == SW_LAST) begin
                  r_sweep_cnt <= '0;
                  r_state     <= S_PUBLISH;
                end else begin
                  r_sweep_cnt <= r_sweep_cnt + 1'b1;
                  r_state     <= enable ? S_RD : S_IDLE;
                end
              end else begin
                r_ch_idx <= r_ch_idx + 1'b1;
              end
            end
          end
          S_PUBLISH: begin
            for (int k = 0; k < N_CH; k++) begin
              r_ch_data[k*DATA_W +: DATA_W] <= DATA_W'(r_acc[k] >> AVG_LOG2);
            end
            r_state <= enable ? S_RD : S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_poller.sv
// tb/tb_adc_poller.sv - directed self-checking bench for adc_poller
module tb_adc_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // instance A: no averaging, short timeout
  logic        en_a;
  logic        wr_a, rd_a, wq_a, sd_a, te_a;
  logic [2:0]  ad_a;
  logic [31:0] wd_a, rdd_a;
  logic [71:0] cd_a;

  // instance B: four-sweep averaging, zero-wait slave
  logic        en_b;
  logic        wr_b, rd_b, wq_b, sd_b, te_b;
  logic [2:0]  ad_b;
  logic [31:0] wd_b, rdd_b;
  logic [71:0] cd_b;

  adc_poller #(.N_CH(6), .DATA_W(12), .AVG_LOG2(0), .TIMEOUT(8), .INIT_WD(32'hA5A5_0001)) u_a (
    .clk(clk), .reset_n(rst_n), .enable(en_a),
    .avm_write(wr_a), .avm_read(rd_a), .avm_address(ad_a), .avm_writedata(wd_a),
    .avm_readdata(rdd_a), .avm_waitrequest(wq_a),
    .ch_data(cd_a), .sweep_done(sd_a), .timeout_err(te_a)
  );

  adc_poller #(.N_CH(6), .DATA_W(12), .AVG_LOG2(2), .TIMEOUT(1024), .INIT_WD(32'h0)) u_b (
    .clk(clk), .reset_n(rst_n), .enable(en_b),
    .avm_write(wr_b), .avm_read(rd_b), .avm_address(ad_b), .avm_writedata(wd_b),
    .avm_readdata(rdd_b), .avm_waitrequest(wq_b),
    .ch_data(cd_b), .sweep_done(sd_b), .timeout_err(te_b)
  );

  // slave A: mode 0 zero-wait, mode 1 three stall cycles per read, mode 2 stuck on address 3
  int mode_a = 0;
  int base_a = 100;
  int stall_a = 0;
  always_comb begin
    wq_a = 1'b0;
    if (mode_a == 1 && rd_a && stall_a < 3) wq_a = 1'b1;
    if (mode_a == 2 && rd_a && ad_a == 3'd3) wq_a = 1'b1;
    rdd_a = wq_a ? 32'hDEAD_0BAD : 32'(base_a) + 32'(ad_a);
  end

  // slave B: channel 0 follows a per-sweep table, channel k returns 4k+sweep
  int avg_tbl [4] = '{10, 20, 30, 41};
  int sweep_b = 0;
  assign wq_b = 1'b0;
  always_comb begin
    rdd_b = 32'(avg_tbl[sweep_b % 4]);
    if (ad_b != 3'd0) rdd_b = 32'(4 * int'(ad_b)) + 32'(sweep_b);
  end

  // bus monitors
  logic [3:0]  q_a [$];
  int          done_a = 0, stalls_a = 0, stab_bad_a = 0, stuck_a = 0;
  int          cyc = 0, last_done_a = 0, gap_a = 0;
  logic        prev_stall_a = 1'b0;
  logic [2:0]  prev_addr_a = 3'd0;
  logic [71:0] snap_a = '0;
  int          done_b = 0;
  logic [71:0] snap_b = '0;

  always @(posedge clk) begin
    if ((wr_a || rd_a) && !wq_a) q_a.push_back({wr_a, ad_a});
    if (rd_a && wq_a) stalls_a <= stalls_a + 1;
    if (rd_a && wq_a && ad_a == 3'd3) stuck_a <= stuck_a + 1;
    stall_a <= (rd_a && wq_a) ? stall_a + 1 : 0;
    if (prev_stall_a && !(rd_a && ad_a == prev_addr_a)) stab_bad_a <= stab_bad_a + 1;
    prev_stall_a <= rd_a && wq_a;
    prev_addr_a  <= ad_a;
    if (sd_a) begin
      done_a      <= done_a + 1;
      snap_a      <= cd_a;
      gap_a       <= cyc - last_done_a;
      last_done_a <= cyc;
    end
    if (rd_b && ad_b == 3'd5) sweep_b <= sweep_b + 1;
    if (sd_b) begin
      done_b <= done_b + 1;
      snap_b <= cd_b;
    end
    cyc <= cyc + 1;
  end

  task automatic test_reset();
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_a !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", wr_a); end
    total++; if (rd_a !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", rd_a); end
    total++; if (sd_a !== 1'b0) begin bad++; $display("FAIL reset_sweep_done got=%b exp=0", sd_a); end
    total++; if (te_a !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b exp=0", te_a); end
    total++; if (cd_a !== 72'h0) begin bad++; $display("FAIL reset_ch_data got=%h exp=0", cd_a); end
    total++; if (cd_b !== 72'h0) begin bad++; $display("FAIL reset_ch_data_b got=%h exp=0", cd_b); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0] exp_seq [8];
    int q0 = q_a.size();
    int d0 = done_a;
    exp_seq = '{4'h8, 4'h9, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    mode_a = 0; base_a = 100; en_a = 1'b1;
    for (int i = 0; i < 200 && done_a == d0; i++) @(negedge clk);
    total++; if (done_a == d0) begin bad++; $display("FAIL basic_wait_done got=none exp=pulse"); end
    total++; if (wd_a !== 32'hA5A5_0001) begin bad++; $display("FAIL basic_writedata got=%h exp=a5a50001", wd_a); end
    total++;
    if (q_a.size() < q0 + 8) begin
      bad++; $display("FAIL basic_xfer_count got=%0d exp>=8", q_a.size() - q0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (q_a[q0+i] !== exp_seq[i]) begin bad++; $display("FAIL basic_xfer[%0d] got=%h exp=%h", i, q_a[q0+i], exp_seq[i]); end
      end
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (snap_a[k*12 +: 12] !== 12'(100 + k)) begin bad++; $display("FAIL basic_ch%0d got=%0d exp=%0d", k, snap_a[k*12 +: 12], 100 + k); end
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_a;
    for (int i = 0; i < 100 && done_a < d0 + 2; i++) @(negedge clk);
    total++; if (done_a < d0 + 2) begin bad++; $display("FAIL b2b_wait got=%0d exp=2", done_a - d0); end
    total++; if (gap_a !== 7) begin bad++; $display("FAIL b2b_sweep_period got=%0d exp=7", gap_a); end
  endtask

  task automatic test_enable_drop();
    int q0, d0, i;
    for (i = 0; i < 50 && !(rd_a && ad_a == 3'd2); i++) @(negedge clk);
    total++; if (!(rd_a && ad_a == 3'd2)) begin bad++; $display("FAIL drop_find_ch2 got=%0d exp=2", ad_a); end
    en_a = 1'b0; q0 = q_a.size(); d0 = done_a;
    repeat (30) @(negedge clk);
    total++;
    if (q_a.size() - q0 !== 4) begin
      bad++; $display("FAIL drop_xfer_count got=%0d exp=4", q_a.size() - q0);
    end else begin
      for (int j = 0; j < 4; j++) begin
        total++;
        if (q_a[q0+j] !== 4'(2 + j)) begin bad++; $display("FAIL drop_xfer[%0d] got=%h exp=%h", j, q_a[q0+j], 4'(2 + j)); end
      end
    end
    total++; if (done_a - d0 !== 1) begin bad++; $display("FAIL drop_done_count got=%0d exp=1", done_a - d0); end
    total++; if (rd_a !== 1'b0 || wr_a !== 1'b0) begin bad++; $display("FAIL drop_parked got=%b%b exp=00", wr_a, rd_a); end
    q0 = q_a.size();
    en_a = 1'b1;
    for (i = 0; i < 20 && q_a.size() == q0; i++) @(negedge clk);
    en_a = 1'b0;
    total++;
    if (q_a.size() == q0) begin bad++; $display("FAIL resume_no_xfer got=none exp=read0"); end
    else if (q_a[q0] !== 4'h0) begin bad++; $display("FAIL resume_first got=%h exp=0", q_a[q0]); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_wait();
    int s0 = stalls_a, b0 = stab_bad_a, q0 = q_a.size(), d0 = done_a;
    mode_a = 1; base_a = 200;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 200 && done_a == d0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    total++; if (done_a - d0 !== 1) begin bad++; $display("FAIL wait_done_count got=%0d exp=1", done_a - d0); end
    total++; if (stalls_a - s0 !== 18) begin bad++; $display("FAIL wait_stall_cycles got=%0d exp=18", stalls_a - s0); end
    total++; if (stab_bad_a - b0 !== 0) begin bad++; $display("FAIL wait_stable got=%0d exp=0", stab_bad_a - b0); end
    total++; if (q_a.size() - q0 !== 6) begin bad++; $display("FAIL wait_xfer_count got=%0d exp=6", q_a.size() - q0); end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (snap_a[k*12 +: 12] !== 12'(200 + k)) begin bad++; $display("FAIL wait_ch%0d got=%0d exp=%0d", k, snap_a[k*12 +: 12], 200 + k); end
    end
  endtask

  task automatic test_timeout();
    int st0 = stuck_a, d0 = done_a, q0;
    mode_a = 2; base_a = 300;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 100 && !te_a; i++) @(negedge clk);
    total++; if (te_a !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b exp=1", te_a); end
    total++; if (stuck_a - st0 !== 8) begin bad++; $display("FAIL tmo_stuck_cycles got=%0d exp=8", stuck_a - st0); end
    total++; if (rd_a !== 1'b0) begin bad++; $display("FAIL tmo_read_dropped got=%b exp=0", rd_a); end
    total++; if (done_a - d0 !== 0) begin bad++; $display("FAIL tmo_no_publish got=%0d exp=0", done_a - d0); end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (cd_a[k*12 +: 12] !== 12'(200 + k)) begin bad++; $display("FAIL tmo_ch%0d_kept got=%0d exp=%0d", k, cd_a[k*12 +: 12], 200 + k); end
    end
    mode_a = 0;
    q0 = q_a.size();
    repeat (10) @(negedge clk);
    total++; if (q_a.size() - q0 !== 0) begin bad++; $display("FAIL tmo_idle_quiet got=%0d exp=0", q_a.size() - q0); end
    d0 = done_a;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 100 && done_a == d0; i++) @(negedge clk);
    total++;
    if (q_a.size() < q0 + 2) begin bad++; $display("FAIL tmo_restart_count got=%0d exp>=2", q_a.size() - q0); end
    else if (q_a[q0] !== 4'h8 || q_a[q0+1] !== 4'h9) begin bad++; $display("FAIL tmo_restart_writes got=%h%h exp=89", q_a[q0], q_a[q0+1]); end
    total++; if (te_a !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", te_a); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_avg();
    en_b = 1'b1;
    for (int i = 0; i < 300 && done_b == 0; i++) @(negedge clk);
    en_b = 1'b0;
    total++; if (sweep_b !== 4) begin bad++; $display("FAIL avg_sweeps_before_done got=%0d exp=4", sweep_b); end
    total++; if (snap_b[11:0] !== 12'd25) begin bad++; $display("FAIL avg_ch0 got=%0d exp=25", snap_b[11:0]); end
    for (int k = 1; k < 6; k++) begin
      total++;
      if (snap_b[k*12 +: 12] !== 12'(4 * k + 1)) begin bad++; $display("FAIL avg_ch%0d got=%0d exp=%0d", k, snap_b[k*12 +: 12], 4 * k + 1); end
    end
    repeat (40) @(negedge clk);
    total++; if (done_b !== 1) begin bad++; $display("FAIL avg_single_done got=%0d exp=1", done_b); end
    total++; if (rd_b !== 1'b0) begin bad++; $display("FAIL avg_parked got=%b exp=0", rd_b); end
  endtask

  task automatic test_reset_mid();
    int q0;
    mode_a = 0; base_a = 100;
    en_a = 1'b1;
    for (int i = 0; i < 50 && !rd_a; i++) @(negedge clk);
    total++; if (rd_a !== 1'b1) begin bad++; $display("FAIL rstmid_read_active got=%b exp=1", rd_a); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rd_a !== 1'b0) begin bad++; $display("FAIL rstmid_read got=%b exp=0", rd_a); end
    total++; if (wr_a !== 1'b0) begin bad++; $display("FAIL rstmid_write got=%b exp=0", wr_a); end
    total++; if (cd_a !== 72'h0) begin bad++; $display("FAIL rstmid_ch_data got=%h exp=0", cd_a); end
    total++; if (te_a !== 1'b0) begin bad++; $display("FAIL rstmid_timeout_err got=%b exp=0", te_a); end
    total++; if (sd_a !== 1'b0) begin bad++; $display("FAIL rstmid_sweep_done got=%b exp=0", sd_a); end
    @(negedge clk);
    q0 = q_a.size();
    rst_n = 1'b1;
    for (int i = 0; i < 20 && q_a.size() == q0; i++) @(negedge clk);
    total++;
    if (q_a.size() == q0) begin bad++; $display("FAIL rstmid_no_xfer got=none exp=write0"); end
    else if (q_a[q0] !== 4'h8) begin bad++; $display("FAIL rstmid_first got=%h exp=8", q_a[q0]); end
    en_a = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_enable_drop();
    test_wait();
    test_timeout();
    test_avg();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
